// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic LEGv8 instructions (op, register fields, immediate)
// into 32-bit machine words and streams them, with byte addresses, toward the
// instruction-memory loader through a one-entry valid/ready output stage.
// Optional feature macro: IMM_RANGE_CHECK_EN drops inputs whose immediate does
// not fit the instruction's field (err_code 2'b10); without it immediates are
// silently truncated.
module instr_encoder #(
    parameter int          ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [25:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [15:0]       count
);

    localparam logic [3:0] OP_B    = 4'd0;
    localparam logic [3:0] OP_BL   = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_ADDS = 4'd3;
    localparam logic [3:0] OP_SUBS = 4'd4;
    localparam logic [3:0] OP_BLT  = 4'd5;
    localparam logic [3:0] OP_CBZ  = 4'd6;
    localparam logic [3:0] OP_BR   = 4'd7;
    localparam logic [3:0] OP_LDUR = 4'd8;
    localparam logic [3:0] OP_STUR = 4'd9;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;

    // Field packing; immediates are truncated to the width of their field.
    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rn,
        input logic [4:0]  rm,
        input logic [25:0] imm
    );
        logic [31:0] word;
        word = '0;
        case (op)
            OP_B:    word = {6'b000101, imm};
            OP_BL:   word = {6'b100101, imm};
            OP_ADDI: word = {10'b1001000100, imm[11:0], rn, rd};
            OP_ADDS: word = {11'b10101011000, rm, 6'b000000, rn, rd};
            OP_SUBS: word = {11'b11101011000, rm, 6'b000000, rn, rd};
            OP_BLT:  word = {8'b01010100, imm[18:0], 5'b01011};
            OP_CBZ:  word = {8'b10110100, imm[18:0], rd};
            OP_BR:   word = {11'b11010110000, 5'b11111, 6'b000000, rn, 5'b00000};
            OP_LDUR: word = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
            OP_STUR: word = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
            default: word = '0;
        endcase
        return word;
    endfunction

`ifdef IMM_RANGE_CHECK_EN
    // A signed field fits when every bit above its sign bit repeats the sign bit.
    function automatic logic imm_in_range(input logic [3:0] op, input logic [25:0] imm);
        logic ok;
        case (op)
            OP_ADDI:          ok = (imm[25:12] == 14'd0);
            OP_BLT, OP_CBZ:   ok = (imm[25:18] == {8{imm[18]}});
            OP_LDUR, OP_STUR: ok = (imm[25:8] == {18{imm[8]}});
            default:          ok = 1'b1;
        endcase
        return ok;
    endfunction
`endif

    logic        accept;
    logic        transfer;
    logic        op_legal;
    logic        range_ok;
    logic        word_ok;
    logic [31:0] enc_word;

    assign in_ready = !start && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;
    assign op_legal = (in_op <= OP_STUR);
    assign enc_word = encode(in_op, in_rd, in_rn, in_rm, in_imm);

`ifdef IMM_RANGE_CHECK_EN
    assign range_ok = imm_in_range(in_op, in_imm);
`else
    assign range_ok = 1'b1;
`endif

    assign word_ok = op_legal && range_ok;

    // Output word register: load on an accepted legal input, empty after transfer or start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
        end else if (start) begin
            out_valid <= 1'b0;
        end else if (accept && word_ok) begin
            out_valid <= 1'b1;
            out_instr <= enc_word;
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end

    // Address pointer and saturating word counter advance once per completed transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr <= BASE;
            count    <= '0;
        end else if (start) begin
            out_addr <= BASE;
            count    <= '0;
        end else if (transfer) begin
            out_addr <= out_addr + STEP;
            if (count != 16'hFFFF) begin
                count <= count + 16'd1;
            end
        end
    end

    // Drop reporting: one-cycle pulse per dropped input, code held until the next drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            err_valid <= 1'b0;
            if (accept && !op_legal) begin
                err_valid <= 1'b1;
                err_code  <= ERR_ILLEGAL;
            end else if (accept && !range_ok) begin
                err_valid <= 1'b1;
                err_code  <= ERR_RANGE;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus a randomized stream checked
// against an arithmetic reference encoder and an in-order word scoreboard.
// Honours IMM_RANGE_CHECK_EN the same way the design does.
module tb_instr_encoder;

    localparam int AW   = 8;
    localparam int BASE = 0;
    localparam int STEP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [3:0]    in_op = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rn = '0;
    logic [4:0]    in_rm = '0;
    logic [25:0]   in_imm = '0;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          err_valid;
    logic [1:0]    err_code;
    logic [15:0]   count;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0]   instr;
        logic [AW-1:0] addr;
    } word_t;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_valid(err_valid), .err_code(err_code), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Reference encoder: opcode value scaled into place plus field values.
    function automatic logic [31:0] model_word(input int op, input int rd, input int rn,
                                               input int rm, input longint imm);
        longint w;
        case (op)
            0: w = 64'd5  * (64'd1 << 26) + imm;
            1: w = 64'd37 * (64'd1 << 26) + imm;
            2: w = 64'h244 * (64'd1 << 22) + (imm % 4096) * 1024 + rn * 32 + rd;
            3: w = 64'h558 * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
            4: w = 64'h758 * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
            5: w = 64'h54 * (64'd1 << 24) + (imm % (64'd1 << 19)) * 32 + 11;
            6: w = 64'hB4 * (64'd1 << 24) + (imm % (64'd1 << 19)) * 32 + rd;
            7: w = 64'h6B0 * (64'd1 << 21) + 31 * 65536 + rn * 32;
            8: w = 64'h7C2 * (64'd1 << 21) + (imm % 512) * 4096 + rn * 32 + rd;
            9: w = 64'h7C0 * (64'd1 << 21) + (imm % 512) * 4096 + rn * 32 + rd;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    // Returns 0 when the input yields a word, otherwise the expected err_code.
    function automatic int model_drop(input int op, input longint imm);
`ifdef IMM_RANGE_CHECK_EN
        longint s;
`endif
        if (op > 9) return 1;
`ifdef IMM_RANGE_CHECK_EN
        s = (imm >= (64'd1 << 25)) ? imm - (64'd1 << 26) : imm;
        if (op == 2 && imm > 4095) return 2;
        if ((op == 5 || op == 6) && (s < -(64'sd1 <<< 18) || s >= (64'sd1 <<< 18))) return 2;
        if ((op == 8 || op == 9) && (s < -256 || s > 255)) return 2;
`endif
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op, input int rd, input int rn, input int rm,
                         input logic [25:0] imm);
        in_valid = 1'b1;
        in_op    = 4'(op);
        in_rd    = 5'(rd);
        in_rn    = 5'(rn);
        in_rm    = 5'(rm);
        in_imm   = imm;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_instr !== 32'h0) $display("FAIL reset_instr: got %h want 00000000", out_instr); else passed++;
        total++; if (out_addr !== AW'(BASE)) $display("FAIL reset_addr: got %h want %h", out_addr, AW'(BASE)); else passed++;
        total++; if (err_valid !== 1'b0) $display("FAIL reset_err_valid: got %b want 0", err_valid); else passed++;
        total++; if (err_code !== 2'b00) $display("FAIL reset_err_code: got %b want 00", err_code); else passed++;
        total++; if (count !== 16'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(2, 1, 2, 0, 26'd5);
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL addi_valid: got %b want 1", out_valid); else passed++;
        total++; if (out_instr !== 32'h91001441) $display("FAIL addi_instr: got %h want 91001441", out_instr); else passed++;
        total++; if (out_addr !== 8'd0) $display("FAIL addi_addr: got %h want 00", out_addr); else passed++;
        drive(0, 0, 0, 0, 26'h3FFFFFF);
        tick();
        total++; if (out_instr !== 32'h17FFFFFF) $display("FAIL b_instr: got %h want 17ffffff", out_instr); else passed++;
        total++; if (out_addr !== 8'd4) $display("FAIL b_addr: got %h want 04", out_addr); else passed++;
        total++; if (count !== 16'd1) $display("FAIL b_count_held: got %0d want 1", count); else passed++;
        in_valid = 1'b0;
        tick();
        total++; if (count !== 16'd2) $display("FAIL b_count_done: got %0d want 2", count); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL b_drained: got %b want 0", out_valid); else passed++;
        total++; if (out_addr !== 8'd8) $display("FAIL b_next_addr: got %h want 08", out_addr); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] stur_word;
        stur_word = model_word(9, 7, 9, 0, 64'h3FFFFF0);
        out_ready = 1'b0;
        drive(8, 3, 4, 0, 26'd8);
        tick();
        total++; if (out_instr !== 32'hF8408083) $display("FAIL ldur_instr: got %h want f8408083", out_instr); else passed++;
        total++; if (out_addr !== 8'd8) $display("FAIL ldur_addr: got %h want 08", out_addr); else passed++;
        drive(9, 7, 9, 0, 26'h3FFFFF0);
        for (int i = 0; i < 3; i++) begin
            total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); else passed++;
            tick();
            total++; if (out_instr !== 32'hF8408083 || out_valid !== 1'b1 || out_addr !== 8'd8)
                $display("FAIL bp_hold[%0d]: got v=%b %h@%h want v=1 f8408083@08", i, out_valid, out_instr, out_addr);
            else passed++;
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else passed++;
        tick();
        total++; if (out_instr !== stur_word) $display("FAIL stur_instr: got %h want %h", out_instr, stur_word); else passed++;
        total++; if (out_addr !== 8'd12) $display("FAIL stur_addr: got %h want 0c", out_addr); else passed++;
        in_valid = 1'b0;
        tick();
        total++; if (count !== 16'd4 || out_addr !== 8'd16) $display("FAIL bp_after: got count=%0d addr=%h want 4 10", count, out_addr); else passed++;
    endtask

    task automatic test_illegal();
        drive(15, 1, 1, 1, 26'd0);
        tick();
        total++; if (err_valid !== 1'b1) $display("FAIL illegal_err_valid: got %b want 1", err_valid); else passed++;
        total++; if (err_code !== 2'b01) $display("FAIL illegal_err_code: got %b want 01", err_code); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL illegal_no_word: got %b want 0", out_valid); else passed++;
        total++; if (out_addr !== 8'd16) $display("FAIL illegal_addr: got %h want 10", out_addr); else passed++;
        in_valid = 1'b0;
        tick();
        total++; if (err_valid !== 1'b0) $display("FAIL illegal_pulse_len: got %b want 0", err_valid); else passed++;
        total++; if (err_code !== 2'b01) $display("FAIL illegal_code_hold: got %b want 01", err_code); else passed++;
    endtask

    task automatic test_imm_range();
        int ops  [3] = '{8, 2, 5};
        int imms [3] = '{256, 4096, 262144};
        int code;
        logic [31:0] w;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            code = model_drop(ops[i], longint'(imms[i]));
            w    = model_word(ops[i], 3, 4, 0, longint'(imms[i]));
            drive(ops[i], 3, 4, 0, 26'(imms[i]));
            tick();
            in_valid = 1'b0;
            if (code != 0) begin
                total++; if (err_valid !== 1'b1 || err_code !== 2'(code) || out_valid !== 1'b0)
                    $display("FAIL range_drop[%0d]: got ev=%b ec=%b ov=%b want 1 %b 0", i, err_valid, err_code, out_valid, 2'(code));
                else passed++;
            end else begin
                total++; if (out_valid !== 1'b1 || out_instr !== w || err_valid !== 1'b0)
                    $display("FAIL range_keep[%0d]: got ov=%b %h ev=%b want 1 %h 0", i, out_valid, out_instr, err_valid, w);
                else passed++;
            end
            tick();
        end
`ifndef IMM_RANGE_CHECK_EN
        total++; if (32'hF8500083 !== model_word(8, 3, 4, 0, 256) || err_code !== 2'b01)
            $display("FAIL ldur256_trunc: err_code=%b want 01", err_code);
        else passed++;
`endif
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive(2, 5, 6, 0, 26'd77);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL mid_loaded: got %b want 1", out_valid); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_addr !== 8'd0) $display("FAIL mid_reset_addr: got %h want 00", out_addr); else passed++;
        total++; if (count !== 16'd0) $display("FAIL mid_reset_count: got %0d want 0", count); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL mid_no_resume: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_start();
        out_ready = 1'b1;
        drive(3, 1, 2, 3, 26'd0);
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (count !== 16'd1 || out_addr !== 8'd4) $display("FAIL start_pre: got count=%0d addr=%h want 1 04", count, out_addr); else passed++;
        start = 1'b1;
        drive(2, 1, 1, 1, 26'd1);
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL start_in_ready: got %b want 0", in_ready); else passed++;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        total++; if (count !== 16'd0 || out_addr !== 8'd0 || out_valid !== 1'b0)
            $display("FAIL start_clear: got count=%0d addr=%h ov=%b want 0 00 0", count, out_addr, out_valid);
        else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL start_not_accepted: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        int n = 70;
        int bad = 0;
        logic [31:0] w;
        logic [AW-1:0] a;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(3, i % 32, (i * 7) % 32, (i * 3) % 32, 26'd0);
            tick();
            w = model_word(3, i % 32, (i * 7) % 32, (i * 3) % 32, 0);
            a = AW'((BASE + STEP * i) % (1 << AW));
            total++;
            if (out_valid !== 1'b1 || out_instr !== w || out_addr !== a) begin
                bad++;
                if (bad <= 5) $display("FAIL b2b[%0d]: got ov=%b %h@%h want 1 %h@%h", i, out_valid, out_instr, out_addr, w, a);
            end else passed++;
        end
        in_valid = 1'b0;
        tick();
        total++; if (count !== 16'(n)) $display("FAIL b2b_count: got %0d want %0d", count, n); else passed++;
        total++; if (out_addr !== AW'((BASE + STEP * n) % (1 << AW))) $display("FAIL b2b_wrap_addr: got %h want %h", out_addr, AW'((BASE + STEP * n) % (1 << AW))); else passed++;
    endtask

    task automatic test_random();
        word_t q[$];
        word_t exp_w;
        int nxt = 0;
        int xfers = 0;
        int err_pend = 0;
        int err_exp = 0;
        int op, rd, rn, rm, code;
        logic [25:0] imm;
        start = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            op = $urandom_range(0, 11);
            rd = $urandom_range(0, 31);
            rn = $urandom_range(0, 31);
            rm = $urandom_range(0, 31);
            case ($urandom_range(0, 2))
                0: imm = 26'($urandom_range(0, 300));
                1: imm = 26'(-$urandom_range(1, 300));
                default: imm = 26'($urandom);
            endcase
            drive(op, rd, rn, rm, imm);
            in_valid = ($urandom_range(0, 2) != 0);
            #1;
            total++; if (count !== 16'(xfers)) $display("FAIL rnd_count[%0d]: got %0d want %0d", cyc, count, xfers); else passed++;
            total++; if (err_valid !== (err_pend != 0)) $display("FAIL rnd_err_valid[%0d]: got %b want %0d", cyc, err_valid, err_pend); else passed++;
            if (err_pend != 0) begin
                total++; if (err_code !== 2'(err_exp)) $display("FAIL rnd_err_code[%0d]: got %b want %0d", cyc, err_code, err_exp); else passed++;
            end
            err_pend = 0;
            total++; if (out_valid !== (q.size() != 0)) $display("FAIL rnd_out_valid[%0d]: got %b want %0d", cyc, out_valid, q.size()); else passed++;
            total++; if (in_ready !== (!out_valid || out_ready)) $display("FAIL rnd_in_ready[%0d]: got %b", cyc, in_ready); else passed++;
            if (out_valid && out_ready && q.size() != 0) begin
                exp_w = q.pop_front();
                total++; if (out_instr !== exp_w.instr || out_addr !== exp_w.addr)
                    $display("FAIL rnd_word[%0d]: got %h@%h want %h@%h", cyc, out_instr, out_addr, exp_w.instr, exp_w.addr);
                else passed++;
                xfers++;
            end
            if (in_valid && in_ready) begin
                code = model_drop(op, longint'(imm));
                if (code == 0) begin
                    exp_w.instr = model_word(op, rd, rn, rm, longint'(imm));
                    exp_w.addr  = AW'((BASE + STEP * nxt) % (1 << AW));
                    q.push_back(exp_w);
                    nxt++;
                end else begin
                    err_pend = 1;
                    err_exp  = code;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        total++; if (out_valid !== 1'b0 || count !== 16'(nxt))
            $display("FAIL rnd_final: got ov=%b count=%0d want 0 %0d", out_valid, count, nxt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_illegal();
        test_imm_range();
        test_reset_midflight();
        test_start();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
